// File: rtl/cpu_pkg.sv
// Shared CPU definitions: divider FSM states, ALU control codes and divider constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;

  // ALU control codes; the decoder turns CTRL_DIV/CTRL_DIVU into start/signed_op.
  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_DIV  = 4'b1100;
  localparam logic [3:0] CTRL_DIVU = 4'b1101;

  // Replicated to the divider width at use: quotient reported on divide-by-zero.
  localparam logic DIV_ZERO_QUOT = 1'b1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration on magnitudes: shift in a dividend bit, trial-subtract.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] div_mag,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem_in < div_mag, so the shifted value fits in WIDTH+1 bits and a
  // negative trial result always shows up in its top bit.
  assign shifted = {rem_in, bit_in};
  assign trial   = shifted - {1'b0, div_mag};
  assign q_bit   = ~trial[WIDTH];
  assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned integer divider with start/busy/done handshake,
// one quotient bit per cycle, sign fix-up and divide-by-zero flag.
module div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state, state_next;
  logic [WIDTH-1:0] a_reg;      // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] p_reg;
  logic [CW-1:0]    count;
  logic             sign_q, sign_r, zero_flag;

  logic             dvd_neg, dvs_neg, dvs_zero;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] p_next;
  logic             q_bit;

  assign dvd_neg  = signed_op & dividend[WIDTH-1];
  assign dvs_neg  = signed_op & divisor[WIDTH-1];
  assign dvs_zero = (divisor == '0);
  assign dvd_mag  = dvd_neg ? -dividend : dividend;
  assign dvs_mag  = dvs_neg ? -divisor  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (p_reg),
    .bit_in  (a_reg[WIDTH-1]),
    .div_mag (b_mag),
    .rem_out (p_next),
    .q_bit   (q_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: next-state takes a default first so no path leaves it unassigned
  // (an unassigned path in always_comb would infer a latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = dvs_zero ? FIX : CALC;
      CALC: if (count == '0) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  // NOTE: every datapath register is reset, so an aborted divide leaves
  // nothing behind and outputs read zero while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg       <= '0;
      b_mag       <= '0;
      p_reg       <= '0;
      count       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_flag   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          // On divide-by-zero the raw dividend is kept so it can be returned unmodified.
          a_reg     <= dvs_zero ? dividend : dvd_mag;
          b_mag     <= dvs_mag;
          p_reg     <= '0;
          count     <= CW'(WIDTH - 1);
          sign_q    <= dvd_neg ^ dvs_neg;
          sign_r    <= dvd_neg;
          zero_flag <= dvs_zero;
        end
        CALC: begin
          p_reg <= p_next;
          a_reg <= {a_reg[WIDTH-2:0], q_bit};
          count <= count - CW'(1);
        end
        FIX: begin
          if (zero_flag) begin
            quotient    <= {WIDTH{DIV_ZERO_QUOT}};
            remainder   <= a_reg;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= sign_q ? -a_reg : a_reg;
            remainder   <= sign_r ? -p_reg : p_reg;
            div_by_zero <= 1'b0;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule
